// File: rtl/bram_arbiter.sv
// Two-port round-robin arbiter with locked bursts in front of a single-port BRAM; grant and RAM drive are
// combinational, read data returns one cycle after accept. Losers are held off via req_ready; responses have no backpressure.
module bram_arbiter #(
    parameter int ADDRESSWIDTH = 10,
    parameter int BITWIDTH     = 32,
    parameter int MAX_BURST    = 4
) (
    input  logic                    clk,
    input  logic                    resetn,

    input  logic                    req_valid_0,
    output logic                    req_ready_0,
    input  logic                    req_we_0,
    input  logic                    req_lock_0,
    input  logic [ADDRESSWIDTH-1:0] req_addr_0,
    input  logic [BITWIDTH-1:0]     req_wdata_0,

    input  logic                    req_valid_1,
    output logic                    req_ready_1,
    input  logic                    req_we_1,
    input  logic                    req_lock_1,
    input  logic [ADDRESSWIDTH-1:0] req_addr_1,
    input  logic [BITWIDTH-1:0]     req_wdata_1,

    output logic                    rsp_valid_0,
    output logic [BITWIDTH-1:0]     rsp_rdata_0,
    output logic                    rsp_valid_1,
    output logic [BITWIDTH-1:0]     rsp_rdata_1,

    output logic [ADDRESSWIDTH-1:0] ram_a,
    output logic                    ram_we,
    output logic [BITWIDTH-1:0]     ram_din,
    input  logic [BITWIDTH-1:0]     ram_dout
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic                    rr_last, rr_last_nxt;
    logic [CW-1:0]           beat_cnt, beat_cnt_nxt, beats;

    logic                    gnt_vld;
    logic                    gnt_port;
    logic                    gnt_we;
    logic                    gnt_lock;
    logic                    same_grant;
    logic [ADDRESSWIDTH-1:0] gnt_addr;
    logic [BITWIDTH-1:0]     gnt_wdata;

    logic                    rsp_pend_0, rsp_pend_1;
    logic [BITWIDTH-1:0]     rdata_hold_0, rdata_hold_1;

    // A held grant wins outright; otherwise arbitrate in the same cycle so a dropped lock costs no bubble.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_port = 1'b0;
        if (!resetn) begin
            gnt_vld = 1'b0;
        end else if (state == GNT0 && req_valid_0) begin
            gnt_vld  = 1'b1;
            gnt_port = 1'b0;
        end else if (state == GNT1 && req_valid_1) begin
            gnt_vld  = 1'b1;
            gnt_port = 1'b1;
        end else if (req_valid_0 && req_valid_1) begin
            gnt_vld  = 1'b1;
            gnt_port = ~rr_last;
        end else if (req_valid_0) begin
            gnt_vld  = 1'b1;
            gnt_port = 1'b0;
        end else if (req_valid_1) begin
            gnt_vld  = 1'b1;
            gnt_port = 1'b1;
        end
    end

    assign gnt_we    = gnt_port ? req_we_1    : req_we_0;
    assign gnt_lock  = gnt_port ? req_lock_1  : req_lock_0;
    assign gnt_addr  = gnt_port ? req_addr_1  : req_addr_0;
    assign gnt_wdata = gnt_port ? req_wdata_1 : req_wdata_0;

    assign req_ready_0 = gnt_vld & ~gnt_port;
    assign req_ready_1 = gnt_vld &  gnt_port;

    assign ram_a   = gnt_vld ? gnt_addr  : req_addr_0;
    assign ram_din = gnt_vld ? gnt_wdata : '0;
    assign ram_we  = gnt_vld & gnt_we;

    assign same_grant = (state == GNT0 && !gnt_port) || (state == GNT1 && gnt_port);

    always_comb begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
        rr_last_nxt  = rr_last;
        beats        = '0;
        if (gnt_vld) begin
            rr_last_nxt = gnt_port;
            beats       = same_grant ? beat_cnt + CW'(1) : CW'(1);
            // The MAX_BURST-th beat always releases the grant, even if still locked.
            if (gnt_lock && beats < CW'(MAX_BURST)) begin
                state_nxt    = gnt_port ? GNT1 : GNT0;
                beat_cnt_nxt = beats;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            rr_last  <= 1'b1;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_last  <= rr_last_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_pend_0   <= 1'b0;
            rsp_pend_1   <= 1'b0;
            rdata_hold_0 <= '0;
            rdata_hold_1 <= '0;
        end else begin
            rsp_pend_0 <= gnt_vld & ~gnt_port & ~gnt_we;
            rsp_pend_1 <= gnt_vld &  gnt_port & ~gnt_we;
            if (rsp_pend_0) begin
                rdata_hold_0 <= ram_dout;
            end
            if (rsp_pend_1) begin
                rdata_hold_1 <= ram_dout;
            end
        end
    end

    // Read data comes straight from the BRAM output in the response cycle, then is held.
    assign rsp_valid_0 = rsp_pend_0;
    assign rsp_valid_1 = rsp_pend_1;
    assign rsp_rdata_0 = rsp_pend_0 ? ram_dout : rdata_hold_0;
    assign rsp_rdata_1 = rsp_pend_1 ? ram_dout : rdata_hold_1;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: a behavioural BRAM plus a transaction-level arbitration/memory model
// checked every cycle under directed and randomized traffic.
module tb_bram_arbiter;

    localparam int AW = 10;
    localparam int BW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          req_valid_0, req_valid_1, req_ready_0, req_ready_1;
    logic          req_we_0, req_we_1, req_lock_0, req_lock_1;
    logic [AW-1:0] req_addr_0, req_addr_1, ram_a;
    logic [BW-1:0] req_wdata_0, req_wdata_1;
    logic          rsp_valid_0, rsp_valid_1, ram_we;
    logic [BW-1:0] rsp_rdata_0, rsp_rdata_1, ram_din, ram_dout;

    always #5 clk = ~clk;

    bram_arbiter #(.ADDRESSWIDTH(AW), .BITWIDTH(BW), .MAX_BURST(MB)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
        .req_lock_0(req_lock_0), .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
        .req_lock_1(req_lock_1), .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
        .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
        .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
        .ram_a(ram_a), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Registered-read BRAM
    logic [BW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_din;
        ram_dout <= mem[ram_a];
    end

    // Transaction-level model: who holds a grant, burst length so far, tie-break memory, memory image.
    int            m_hold, m_cnt, m_pend;
    bit            m_rr;
    logic [BW-1:0] ref_mem [0:(1<<AW)-1];
    logic [BW-1:0] m_pend_dat, m_last0, m_last1;

    int            tests = 0, fails = 0;

    int            e_g, o_g;
    logic          e_we, o_we, e_rv0, o_rv0, e_rv1, o_rv1;
    logic [AW-1:0] e_a, o_a;
    logic [BW-1:0] e_din, o_din, e_rd0, o_rd0, e_rd1, o_rd1;

    task automatic model_reset();
        m_hold = -1; m_cnt = 0; m_rr = 1'b1; m_pend = -1;
        m_last0 = '0; m_last1 = '0;
    endtask

    function automatic int model_grant(input logic v0, input logic v1);
        if (m_hold == 0 && v0) return 0;
        if (m_hold == 1 && v1) return 1;
        if (v0 && v1) return m_rr ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic model_commit(input int g, input logic we, input logic lk,
                                input logic [AW-1:0] a, input logic [BW-1:0] d);
        if (g < 0) begin
            m_hold = -1; m_cnt = 0; m_pend = -1;
        end else begin
            if (we) begin
                ref_mem[a] = d;
                m_pend = -1;
            end else begin
                m_pend = g;
                m_pend_dat = ref_mem[a];
            end
            m_cnt = (m_hold == g) ? m_cnt + 1 : 1;
            m_rr  = (g == 1);
            if (lk && m_cnt < MB) m_hold = g;
            else begin
                m_hold = -1; m_cnt = 0;
            end
        end
    endtask

    task automatic set_idle();
        req_valid_0 = 0; req_valid_1 = 0; req_we_0 = 0; req_we_1 = 0;
        req_lock_0 = 0; req_lock_1 = 0; req_addr_0 = '0; req_addr_1 = '0;
        req_wdata_0 = '0; req_wdata_1 = '0;
    endtask

    // One clock: drive, sample the combinational grant/RAM drive, then sample the response after the edge.
    task automatic step(input logic v0, input logic v1, input logic we0, input logic we1,
                        input logic lk0, input logic lk1, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1, input logic [BW-1:0] d0, input logic [BW-1:0] d1);
        @(negedge clk);
        req_valid_0 = v0; req_valid_1 = v1; req_we_0 = we0; req_we_1 = we1;
        req_lock_0 = lk0; req_lock_1 = lk1; req_addr_0 = a0; req_addr_1 = a1;
        req_wdata_0 = d0; req_wdata_1 = d1;
        #1;
        e_g   = model_grant(v0, v1);
        o_g   = (req_ready_0 && req_ready_1) ? 2 : req_ready_0 ? 0 : req_ready_1 ? 1 : -1;
        e_we  = (e_g == 0) ? we0 : (e_g == 1) ? we1 : 1'b0;
        e_a   = (e_g == 1) ? a1 : a0;
        e_din = (e_g == 0) ? d0 : (e_g == 1) ? d1 : '0;
        o_we  = ram_we; o_a = ram_a; o_din = ram_din;
        if (e_g == 1) model_commit(e_g, we1, lk1, a1, d1);
        else          model_commit(e_g, we0, lk0, a0, d0);
        @(posedge clk);
        #1;
        e_rv0 = (m_pend == 0); e_rv1 = (m_pend == 1);
        if (m_pend == 0) m_last0 = m_pend_dat;
        if (m_pend == 1) m_last1 = m_pend_dat;
        e_rd0 = m_last0; e_rd1 = m_last1;
        o_rv0 = rsp_valid_0; o_rv1 = rsp_valid_1; o_rd0 = rsp_rdata_0; o_rd1 = rsp_rdata_1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 0;
        set_idle();
        repeat (2) @(negedge clk);
        resetn = 1;
        model_reset();
    endtask

    task automatic test_reset();
        resetn = 0;
        req_valid_0 = 1; req_valid_1 = 1; req_we_0 = 1; req_we_1 = 1;
        req_lock_0 = 1; req_lock_1 = 1; req_addr_0 = 10'h2AA; req_addr_1 = 10'h155;
        req_wdata_0 = 32'hA5A5A5A5; req_wdata_1 = 32'h5A5A5A5A;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, ram_we} !== 5'b0 ||
            rsp_rdata_0 !== '0 || rsp_rdata_1 !== '0 || ram_din !== '0) begin
            fails++;
            $display("FAIL reset_outputs: rdy=%b%b rv=%b%b we=%b rd0=%h rd1=%h din=%h, want all zero",
                     req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, ram_we,
                     rsp_rdata_0, rsp_rdata_1, ram_din);
        end
        @(negedge clk);
        set_idle();
        resetn = 1;
        model_reset();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 1, 0, 0, 0, AW'(i), '0, $urandom, '0);
            tests++;
            if (o_g !== e_g || o_we !== e_we || o_a !== e_a || o_din !== e_din) begin
                fails++;
                $display("FAIL fill_grant %0d: got g=%0d we=%b a=%h din=%h, want g=%0d we=%b a=%h din=%h",
                         i, o_g, o_we, o_a, o_din, e_g, e_we, e_a, e_din);
            end
        end
    endtask

    task automatic test_single_read();
        step(1, 0, 1, 0, 0, 0, 10'h005, '0, 32'hDEADBEEF, '0);
        step(1, 0, 0, 0, 0, 0, 10'h005, '0, '0, '0);
        tests++;
        if (o_g !== 0 || o_rv0 !== 1'b1 || o_rd0 !== 32'hDEADBEEF || o_rv1 !== 1'b0) begin
            fails++;
            $display("FAIL single_read: got g=%0d rv0=%b rd0=%h rv1=%b, want g=0 rv0=1 rd0=deadbeef rv1=0",
                     o_g, o_rv0, o_rd0, o_rv1);
        end
    endtask

    task automatic test_tie();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 0, 0, 0, AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), '0, '0);
            tests++;
            if (o_g !== (i % 2) || o_g !== e_g || o_a !== e_a) begin
                fails++;
                $display("FAIL tie_grant %0d: got g=%0d a=%h, want g=%0d a=%h", i, o_g, o_a, i % 2, e_a);
            end
            tests++;
            if ({o_rv0, o_rv1, o_rd0, o_rd1} !== {e_rv0, e_rv1, e_rd0, e_rd1}) begin
                fails++;
                $display("FAIL tie_rsp %0d: got rv=%b%b rd0=%h rd1=%h, want rv=%b%b rd0=%h rd1=%h",
                         i, o_rv0, o_rv1, o_rd0, o_rd1, e_rv0, e_rv1, e_rd0, e_rd1);
            end
        end
    endtask

    task automatic test_burst_cap();
        int exp_seq [10];
        exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 10; i++) begin
            step(i != 0, 1, 1, 1, 0, 1, AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                 $urandom, $urandom);
            tests++;
            if (o_g !== exp_seq[i] || o_g !== e_g || o_we !== e_we || o_a !== e_a || o_din !== e_din) begin
                fails++;
                $display("FAIL burst_cap %0d: got g=%0d we=%b a=%h din=%h, want g=%0d we=%b a=%h din=%h",
                         i, o_g, o_we, o_a, o_din, exp_seq[i], e_we, e_a, e_din);
            end
        end
    endtask

    task automatic test_raw();
        step(1, 0, 1, 0, 0, 0, 10'h3FF, '0, 32'h0000_1234, '0);
        step(1, 0, 0, 0, 0, 0, 10'h3FF, '0, '0, '0);
        tests++;
        if (o_rv0 !== 1'b1 || o_rd0 !== 32'h0000_1234 || o_rd0 !== e_rd0) begin
            fails++;
            $display("FAIL raw: got rv0=%b rd0=%h, want rv0=1 rd0=00001234", o_rv0, o_rd0);
        end
    endtask

    task automatic test_reset_mid_burst();
        step(1, 0, 0, 0, 1, 0, 10'h001, '0, '0, '0);
        step(1, 0, 0, 0, 1, 0, 10'h002, '0, '0, '0);
        resetn = 0;
        #1;
        tests++;
        if (rsp_valid_0 !== 1'b0 || req_ready_0 !== 1'b0) begin
            fails++;
            $display("FAIL midreset_drop: got rv0=%b rdy0=%b, want 0 0", rsp_valid_0, req_ready_0);
        end
        @(negedge clk);
        @(negedge clk);
        set_idle();
        resetn = 1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
            tests++;
            if (o_rv0 !== 1'b0 || o_rv1 !== 1'b0 || o_g !== -1) begin
                fails++;
                $display("FAIL midreset_quiet %0d: got rv=%b%b g=%0d, want rv=00 g=-1", i, o_rv0, o_rv1, o_g);
            end
        end
        step(1, 1, 0, 0, 0, 0, 10'h003, 10'h004, '0, '0);
        tests++;
        if (o_g !== 0 || o_rv0 !== 1'b1 || o_rd0 !== e_rd0) begin
            fails++;
            $display("FAIL midreset_tie: got g=%0d rv0=%b rd0=%h, want g=0 rv0=1 rd0=%h", o_g, o_rv0, o_rd0, e_rd0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                 AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), $urandom, $urandom);
            tests++;
            if (o_g !== e_g || o_we !== e_we || o_a !== e_a || o_din !== e_din) begin
                fails++;
                $display("FAIL rand_grant %0d: got g=%0d we=%b a=%h din=%h, want g=%0d we=%b a=%h din=%h",
                         i, o_g, o_we, o_a, o_din, e_g, e_we, e_a, e_din);
            end
            tests++;
            if ({o_rv0, o_rv1, o_rd0, o_rd1} !== {e_rv0, e_rv1, e_rd0, e_rd1}) begin
                fails++;
                $display("FAIL rand_rsp %0d: got rv=%b%b rd0=%h rd1=%h, want rv=%b%b rd0=%h rd1=%h",
                         i, o_rv0, o_rv1, o_rd0, o_rd1, e_rv0, e_rv1, e_rd0, e_rd1);
            end
        end
    endtask

    initial begin
        resetn = 0;
        set_idle();
        model_reset();
        test_reset();
        test_fill();
        test_single_read();
        test_tie();
        test_burst_cap();
        test_raw();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- ADDRESSWIDTH, 10, BRAM address width.
- BITWIDTH, 32, BRAM data width.
- MAX_BURST, 4, maximum consecutive locked beats per grant (at least 2).
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, all logic on posedge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid_0 / req_valid_1  in  1  request from port 0 / port 1.
- req_ready_0 / req_ready_1  out  1  request accepted this cycle (combinational).
- req_we_0 / req_we_1  in  1  1 = write, 0 = read.
- req_lock_0 / req_lock_1  in  1  request to keep the grant after this beat.
- req_addr_0 / req_addr_1  in  ADDRESSWIDTH  address.
- req_wdata_0 / req_wdata_1  in  BITWIDTH  write data.
- rsp_valid_0 / rsp_valid_1  out  1  read data valid (no backpressure).
- rsp_rdata_0 / rsp_rdata_1  out  BITWIDTH  read data.
- ram_a  out  ADDRESSWIDTH  BRAM address.
- ram_we  out  1  BRAM write enable.
- ram_din  out  BITWIDTH  BRAM write data.
- ram_dout  in  BITWIDTH  BRAM read data (registered address, valid 1 cycle after ram_a).

Function
REQ-003 A beat SHALL be accepted on port i when req_valid_i and req_ready_i are both high; at most one beat SHALL be accepted per cycle.
REQ-004 The FSM SHALL have exactly three states: IDLE, GNT0 and GNT1.
REQ-005 IDLE, single valid: the valid port SHALL be granted.
REQ-006 IDLE, both valid: the port other than rr_last SHALL be granted; rr_last (1 bit) SHALL reset to 1, so port 0 wins the first tie.
REQ-007 GNTi with req_valid_i high: port i SHALL be granted regardless of the other port.
REQ-008 GNTi with req_valid_i low: the block SHALL arbitrate as in IDLE in the same cycle and SHALL move to IDLE unless the new beat is locked.
REQ-009 After an accepted beat on port i, rr_last SHALL be set to i.
REQ-010 After an accepted beat on port i with req_lock_i high, the next state SHALL be GNTi; otherwise the next state SHALL be IDLE.
REQ-011 Beat counter: it SHALL count consecutive accepted beats of one locked grant and SHALL clear on leaving GNTi or on a change of granted port.
REQ-012 When an accepted beat is the MAX_BURST-th consecutive beat, the next state SHALL be IDLE even if req_lock_i is high, and the counter SHALL clear.
REQ-013 RAM drive, combinational:
- ram_a and ram_din SHALL take the granted port's address and data.
- ram_we SHALL equal accept AND req_we of the granted port.
- With no grant: ram_a SHALL take req_addr_0, ram_din SHALL be 0 and ram_we SHALL be 0.
REQ-014 For each accepted read on port i in cycle N, rsp_valid_i SHALL be high for exactly one cycle in N+1, with rsp_rdata_i equal to ram_dout in that cycle.
REQ-015 Accepted writes SHALL produce no response.
REQ-016 rsp_valid_0 and rsp_valid_1 SHALL never both be high in the same cycle.
REQ-017 rsp_rdata_i SHALL hold its last value when rsp_valid_i is low.
REQ-018 Read-after-write to the same address in consecutive cycles SHALL return the newly written data; this relies on BRAM write-then-registered-read ordering and the block SHALL add no bypass.
REQ-019 Back-to-back reads SHALL sustain one beat per cycle, with no bubbles between grants.

Reset
REQ-020 While resetn is low, the block SHALL hold state IDLE, beat counter 0 and rr_last 1.
REQ-021 While resetn is low, all of the following outputs SHALL be 0: req_ready_*, rsp_valid_*, rsp_rdata_*, ram_we and ram_din.
REQ-022 Reset asserted mid-burst or with a read in flight SHALL drop the pending response, and no rsp_valid SHALL appear after resetn rises.

Verification
REQ-023 Single read: preload addr 0x005 = 0xDEADBEEF; port 0 reads 0x005 in cycle N -> rsp_valid_0 = 1 with 0xDEADBEEF in N+1, and rsp_valid_1 stays 0.
REQ-024 Tie alternation: both ports issue unlocked reads continuously for 6 cycles after reset -> grants are 0,1,0,1,0,1 and each response arrives one cycle after its grant.
REQ-025 Burst cap: port 1 issues locked writes continuously with MAX_BURST = 4 while port 0 is valid -> 4 port-1 beats, then 1 port-0 beat, then port 1 regains the grant.
REQ-026 Read-after-write: port 0 writes 0x1234 to addr 0x3FF, then reads 0x3FF on the next cycle -> rsp_rdata_0 = 0x1234.
REQ-027 Reset mid-burst: resetn low for 1 cycle during a locked port-0 read -> no rsp_valid_0 after reset, state IDLE, and the first tie goes to port 0.
